// File: rtl/rpc2_ctrl_adr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rpc2_ctrl_adr_arbiter_if
//   Bundles the signals around the ADR arbiter: the AXI read-address and
//   write-address command handshakes, the write-data presence flag, and the
//   write side of the shared ADR command FIFO.
//
//   Signals:
//     adr_wr_ar_valid / adr_ar_din / adr_wr_ar_ready : read command handshake
//     adr_wr_aw_valid / adr_aw_din / adr_wr_aw_ready : write command handshake
//     wdata_ready       : write data for the head AW command is in the WDAT FIFO
//     adr_fifo_pre_full : ADR FIFO has two or fewer free entries
//     adr_fifo_wr_en    : ADR FIFO write strobe
//     adr_fifo_din      : {is_write, payload} written to the ADR FIFO
//
//   Modports:
//     master : command sources and FIFO status (the arbiter's environment)
//     slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface rpc2_ctrl_adr_arbiter_if #(
    parameter int ADR_PAYLOAD_WIDTH = 46
);
    logic                         adr_wr_ar_valid;
    logic [ADR_PAYLOAD_WIDTH-1:0] adr_ar_din;
    logic                         adr_wr_ar_ready;

    logic                         adr_wr_aw_valid;
    logic [ADR_PAYLOAD_WIDTH-1:0] adr_aw_din;
    logic                         adr_wr_aw_ready;

    logic                         wdata_ready;
    logic                         adr_fifo_pre_full;

    logic                         adr_fifo_wr_en;
    logic [ADR_PAYLOAD_WIDTH:0]   adr_fifo_din;

    modport master (
        output adr_wr_ar_valid, adr_ar_din,
        output adr_wr_aw_valid, adr_aw_din,
        output wdata_ready, adr_fifo_pre_full,
        input  adr_wr_ar_ready, adr_wr_aw_ready,
        input  adr_fifo_wr_en, adr_fifo_din
    );

    modport slave (
        input  adr_wr_ar_valid, adr_ar_din,
        input  adr_wr_aw_valid, adr_aw_din,
        input  wdata_ready, adr_fifo_pre_full,
        output adr_wr_ar_ready, adr_wr_aw_ready,
        output adr_fifo_wr_en, adr_fifo_din
    );
endinterface

// File: rtl/rpc2_ctrl_adr_arbiter.sv
// ---------------------------------------------------------------------------
// rpc2_ctrl_adr_arbiter
//   Shares the single ADR command FIFO between the AXI read-address path and
//   the AXI write-address path. One command is accepted per cycle, tagged
//   with a read/write bit and written to the FIFO one cycle later through a
//   single register stage. Same-direction runs are kept together, but a run
//   is cut after MAX_CONSEC grants whenever the other side is waiting.
//
//   Ports:
//     clk   : sole clock, rising edge
//     reset : asynchronous, active-high reset
//     bus   : slave modport of rpc2_ctrl_adr_arbiter_if (both command
//             handshakes, wdata_ready, FIFO pre-full and FIFO write port)
// ---------------------------------------------------------------------------
module rpc2_ctrl_adr_arbiter #(
    parameter int ADR_PAYLOAD_WIDTH = 46,
    parameter int MAX_CONSEC        = 4,
    parameter int CNT_WIDTH         = 3
) (
    input logic                      clk,
    input logic                      reset,
    rpc2_ctrl_adr_arbiter_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_CONSEC);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

    logic [1:0]                   state;
    logic [CNT_WIDTH-1:0]         cnt;
    logic [CNT_WIDTH-1:0]         cnt_inc;
    logic                         last_owner;

    logic                         elig_rd;
    logic                         elig_wr;
    logic                         can_issue;
    logic                         grant_rd;
    logic                         grant_wr;

    logic                         fifo_wr_en;
    logic [ADR_PAYLOAD_WIDTH:0]   fifo_din;

    // A write command only competes once its data is already in the WDAT
    // FIFO; the pre-full margin of two covers the one write still in flight
    // in the output register.
    assign elig_rd   = bus.adr_wr_ar_valid;
    assign elig_wr   = bus.adr_wr_aw_valid & bus.wdata_ready;
    assign can_issue = ~bus.adr_fifo_pre_full & ~reset;

    assign cnt_inc   = (cnt == MAX_CNT) ? cnt : cnt + ONE_CNT;

    // Grant selection. The run limit only bites while the opposite side is
    // eligible; an unopposed side keeps streaming with cnt saturated. A
    // write run that loses its wdata_ready hands over to a waiting read at
    // once, regardless of cnt.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (can_issue) begin
            case (state)
                ST_RD: begin
                    if (elig_rd && (!elig_wr || cnt < MAX_CNT)) begin
                        grant_rd = 1'b1;
                    end else if (elig_wr) begin
                        grant_wr = 1'b1;
                    end
                end
                ST_WR: begin
                    if (elig_wr && (!elig_rd || cnt < MAX_CNT)) begin
                        grant_wr = 1'b1;
                    end else if (elig_rd) begin
                        grant_rd = 1'b1;
                    end
                end
                default: begin
                    if (elig_rd && elig_wr) begin
                        grant_rd = last_owner;
                        grant_wr = ~last_owner;
                    end else begin
                        grant_rd = elig_rd;
                        grant_wr = elig_wr;
                    end
                end
            endcase
        end
    end

    // A grant is only ever given to an eligible (hence valid) side, so the
    // grant itself is already "grant & valid".
    assign bus.adr_wr_ar_ready = grant_rd;
    assign bus.adr_wr_aw_ready = grant_wr;

    // Run tracking. A stall leaves state, cnt and last_owner untouched so
    // the run resumes exactly where it paused once the FIFO drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
        end else if (can_issue) begin
            if (grant_rd) begin
                last_owner <= 1'b0;
                if (state == ST_RD) begin
                    cnt <= cnt_inc;
                end else begin
                    state <= ST_RD;
                    cnt   <= ONE_CNT;
                end
            end else if (grant_wr) begin
                last_owner <= 1'b1;
                if (state == ST_WR) begin
                    cnt <= cnt_inc;
                end else begin
                    state <= ST_WR;
                    cnt   <= ONE_CNT;
                end
            end else begin
                state <= ST_IDLE;
                cnt   <= '0;
            end
        end
    end

    // Output stage: one FIFO write per accept, one cycle later. The data
    // register keeps its last value between writes; an async reset drops
    // any accepted command that has not reached the FIFO yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
        end else begin
            fifo_wr_en <= grant_rd | grant_wr;
            if (grant_rd) begin
                fifo_din <= {1'b0, bus.adr_ar_din};
            end else if (grant_wr) begin
                fifo_din <= {1'b1, bus.adr_aw_din};
            end
        end
    end

    assign bus.adr_fifo_wr_en = fifo_wr_en;
    assign bus.adr_fifo_din   = fifo_din;

endmodule
